// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Lets the instruction-fetch port and the data port of the CPU share one
// single-port synchronous SRAM that holds both code and data. Data accesses
// normally win arbitration. A 4-bit streak counter limits how many data
// grants in a row can be given while a fetch is waiting, so fetches are
// never starved.
//
// Every access takes three cycles:
//   IDLE  -> sample requests and latch the winner's command
//   GRANT -> drive the latched command to the SRAM
//   RESP  -> pulse the owner's ack; read data comes straight from the SRAM
//
// Ports
//   clk, rst                : clock; asynchronous active-low reset
//   code_address            : fetch byte address
//   code_read_enable        : fetch request, held until code_ack
//   code_read_data/code_ack : fetch data and one-cycle completion pulse
//   data_address            : load/store byte address
//   data_read_enable        : load request, held until data_read_ack
//   data_write_enable       : store request, held until data_write_ack
//   data_write_byte_enable  : store byte lanes
//   data_write_data         : store data
//   data_read_data/_ack     : load data and one-cycle completion pulse
//   data_write_ack          : one-cycle store completion pulse
//   mem_*                   : command to the SRAM and its registered read data
//   busy                    : high while an access is in GRANT or RESP
module mem_port_arbiter #(
  parameter int ADDR_W          = 10,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       code_address,
  input  logic              code_read_enable,
  output logic [31:0]       code_read_data,
  output logic              code_ack,
  input  logic [31:0]       data_address,
  input  logic              data_read_enable,
  input  logic              data_write_enable,
  input  logic [3:0]        data_write_byte_enable,
  input  logic [31:0]       data_write_data,
  output logic [31:0]       data_read_data,
  output logic              data_read_ack,
  output logic              data_write_ack,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic [3:0]        mem_write_byte_enable,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  input  logic [31:0]       mem_read_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] MAX_STREAK = 4'(MAX_DATA_STREAK);

  state_t            state;
  state_t            next_state;

  // Latched command of the access currently in flight.
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_code;
  logic              cmd_write;
  logic [3:0]        cmd_lanes;
  logic [31:0]       cmd_wdata;

  logic [3:0]        streak;

  logic              data_req;
  logic              any_req;
  logic              pick_code;

  // Byte-offset bits and address bits above the SRAM range are not needed.
  logic              unused_addr_bits;
  assign unused_addr_bits = ^{code_address[31:ADDR_W+2], code_address[1:0],
                              data_address[31:ADDR_W+2], data_address[1:0]};

  // Code only beats a pending data request once the streak has saturated.
  always_comb begin
    data_req  = data_read_enable | data_write_enable;
    any_req   = code_read_enable | data_req;
    pick_code = code_read_enable & (~data_req | (streak == MAX_STREAK));
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = GRANT;
      GRANT:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // All outputs are decoded from the state so that reset clears them at once.
  always_comb begin
    mem_address           = '0;
    mem_write_data        = '0;
    mem_write_byte_enable = '0;
    mem_write_enable      = 1'b0;
    mem_read_enable       = 1'b0;
    code_ack              = 1'b0;
    code_read_data        = '0;
    data_read_ack         = 1'b0;
    data_read_data        = '0;
    data_write_ack        = 1'b0;
    busy                  = (state != IDLE);
    case (state)
      GRANT: begin
        mem_address = cmd_addr;
        if (cmd_write) begin
          mem_write_enable      = 1'b1;
          mem_write_byte_enable = cmd_lanes;
          mem_write_data        = cmd_wdata;
        end else begin
          mem_read_enable = 1'b1;
        end
      end
      RESP: begin
        if (cmd_code) begin
          code_ack       = 1'b1;
          code_read_data = mem_read_data;
        end else if (cmd_write) begin
          data_write_ack = 1'b1;
        end else begin
          data_read_ack  = 1'b1;
          data_read_data = mem_read_data;
        end
      end
      default: ;
    endcase
  end

  // Requests are only looked at in IDLE; the command is frozen for the rest
  // of the access. A simultaneous data read and write is treated as a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cmd_addr  <= '0;
      cmd_code  <= 1'b0;
      cmd_write <= 1'b0;
      cmd_lanes <= '0;
      cmd_wdata <= '0;
      streak    <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE) begin
        if (any_req) begin
          if (pick_code) begin
            cmd_addr  <= code_address[ADDR_W+1:2];
            cmd_code  <= 1'b1;
            cmd_write <= 1'b0;
            cmd_lanes <= '0;
            cmd_wdata <= '0;
          end else begin
            cmd_addr  <= data_address[ADDR_W+1:2];
            cmd_code  <= 1'b0;
            cmd_write <= data_write_enable;
            cmd_lanes <= data_write_byte_enable;
            cmd_wdata <= data_write_data;
          end
        end
        // The streak only counts data grants that made a fetch wait.
        if (!code_read_enable || pick_code) begin
          streak <= '0;
        end else if (data_req && streak != MAX_STREAK) begin
          streak <= streak + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int ADDR_W = 10;
  localparam int MAX_DATA_STREAK = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       code_address;
  logic              code_read_enable;
  logic [31:0]       code_read_data;
  logic              code_ack;
  logic [31:0]       data_address;
  logic              data_read_enable;
  logic              data_write_enable;
  logic [3:0]        data_write_byte_enable;
  logic [31:0]       data_write_data;
  logic [31:0]       data_read_data;
  logic              data_read_ack;
  logic              data_write_ack;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_write_data;
  logic [3:0]        mem_write_byte_enable;
  logic              mem_write_enable;
  logic              mem_read_enable;
  logic [31:0]       mem_read_data;
  logic              busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .code_address(code_address),
    .code_read_enable(code_read_enable),
    .code_read_data(code_read_data),
    .code_ack(code_ack),
    .data_address(data_address),
    .data_read_enable(data_read_enable),
    .data_write_enable(data_write_enable),
    .data_write_byte_enable(data_write_byte_enable),
    .data_write_data(data_write_data),
    .data_read_data(data_read_data),
    .data_read_ack(data_read_ack),
    .data_write_ack(data_write_ack),
    .mem_address(mem_address),
    .mem_write_data(mem_write_data),
    .mem_write_byte_enable(mem_write_byte_enable),
    .mem_write_enable(mem_write_enable),
    .mem_read_enable(mem_read_enable),
    .mem_read_data(mem_read_data),
    .busy(busy)
  );

  // Behavioural single-port SRAM with one cycle of read latency.
  logic [31:0] ram [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (mem_write_enable) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_write_byte_enable[i]) ram[mem_address][8*i +: 8] <= mem_write_data[8*i +: 8];
      end
    end
    if (mem_read_enable) mem_read_data <= ram[mem_address];
  end

  // Port codes: 0 = fetch, 1 = load, 2 = store.
  typedef struct {
    int          port;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops the oldest expectation and compares owner and data.
  int          mon_n;
  int          mon_port;
  logic [31:0] mon_data;
  exp_t        mon_exp;

  always @(negedge clk) begin
    if (rst) begin
      mon_n = int'(code_ack) + int'(data_read_ack) + int'(data_write_ack);
      if (mon_n > 1) begin
        checkOutput("single_ack", mon_n, 1);
      end else if (mon_n == 1) begin
        if (code_ack) begin
          mon_port = 0;
          mon_data = code_read_data | data_read_data;
        end else if (data_read_ack) begin
          mon_port = 1;
          mon_data = data_read_data | code_read_data;
        end else begin
          mon_port = 2;
          mon_data = data_read_data | code_read_data;
        end
        if (sb.size() == 0) begin
          checkOutput("unexpected_ack_port", mon_port, 32'hFFFF_FFFF);
        end else begin
          mon_exp = sb.pop_front();
          checkOutput("ack_port", mon_port, mon_exp.port);
          checkOutput("ack_data", mon_data, mon_exp.data);
        end
      end
    end
  end

  // Issues one uncontended request (called just after a falling edge), checks
  // the GRANT cycle command and the two-cycle ack latency, then releases.
  task automatic applyStimulus(input logic is_code, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [3:0] lanes,
                               input logic [31:0] wdata, input int exp_port,
                               input logic [31:0] exp_data, input string name);
    int lat;
    bit seen;
    if (is_code) begin
      code_read_enable = 1'b1;
      code_address     = addr;
    end else begin
      data_read_enable       = rd;
      data_write_enable      = wr;
      data_address           = addr;
      data_write_byte_enable = lanes;
      data_write_data        = wdata;
    end
    sb.push_back('{exp_port, exp_data});
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        checkOutput({name, "_grant_busy"}, 32'(busy), 32'd1);
        checkOutput({name, "_grant_addr"}, 32'(mem_address), 32'(addr[ADDR_W+1:2]));
        checkOutput({name, "_grant_re"}, 32'(mem_read_enable), (exp_port == 2) ? 32'd0 : 32'd1);
        checkOutput({name, "_grant_we"}, 32'(mem_write_enable), (exp_port == 2) ? 32'd1 : 32'd0);
        if (exp_port == 2) begin
          checkOutput({name, "_grant_wdata"}, mem_write_data, wdata);
          checkOutput({name, "_grant_lanes"}, 32'(mem_write_byte_enable), 32'(lanes));
        end
      end
      case (exp_port)
        0:       seen = code_ack;
        1:       seen = data_read_ack;
        default: seen = data_write_ack;
      endcase
    end
    checkOutput({name, "_latency"}, lat, 32'd2);
    code_read_enable  = 1'b0;
    data_read_enable  = 1'b0;
    data_write_enable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          data_at;
    int          code_at;
    int          acks;
    int          code_pos;
    logic [4:0]  busy_pat;

    rst                    = 1'b0;
    code_address           = '0;
    code_read_enable       = 1'b0;
    data_address           = '0;
    data_read_enable       = 1'b0;
    data_write_enable      = 1'b0;
    data_write_byte_enable = '0;
    data_write_data        = '0;
    mem_read_data          = '0;
    ram[16]                = 32'h0050_0093;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_code_ack", 32'(code_ack), 32'd0);
    checkOutput("rst_dr_ack", 32'(data_read_ack), 32'd0);
    checkOutput("rst_dw_ack", 32'(data_write_ack), 32'd0);
    checkOutput("rst_code_data", code_read_data, 32'd0);
    checkOutput("rst_data_data", data_read_data, 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_address), 32'd0);
    checkOutput("rst_mem_re", 32'(mem_read_enable), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_write_enable), 32'd0);
    checkOutput("rst_mem_wdata", mem_write_data, 32'd0);
    checkOutput("rst_mem_lanes", 32'(mem_write_byte_enable), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Fetch only
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h40, 4'h0, 32'h0, 0, 32'h0050_0093, "fetch");

    // Store, partial store, load
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h100, 4'hF, 32'hDEAD_BEEF, 2, 32'h0, "st_full");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h100, 4'h1, 32'h0000_00AA, 2, 32'h0, "st_byte");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1, 32'hDEAD_BEAA, "ld");

    // Contention: data first, code 3 cycles later, one IDLE cycle between
    code_read_enable = 1'b1;
    code_address     = 32'h40;
    data_read_enable = 1'b1;
    data_address     = 32'h100;
    sb.push_back('{1, 32'hDEAD_BEAA});
    sb.push_back('{0, 32'h0050_0093});
    busy_pat = 5'b11011;
    data_at  = -1;
    code_at  = -1;
    for (int i = 1; i <= 20 && code_at < 0; i++) begin
      @(negedge clk);
      if (i <= 5) checkOutput("cont_busy", 32'(busy), 32'(busy_pat[5-i]));
      if (data_read_ack) begin
        data_at          = i;
        data_read_enable = 1'b0;
      end
      if (code_ack) begin
        code_at          = i;
        code_read_enable = 1'b0;
      end
    end
    code_read_enable = 1'b0;
    data_read_enable = 1'b0;
    checkOutput("cont_data_at", data_at, 32'd2);
    checkOutput("cont_code_at", code_at, 32'd5);
    @(negedge clk);

    // Starvation bound: stores held continuously, fetch held until served
    code_read_enable       = 1'b1;
    code_address           = 32'h40;
    data_write_enable      = 1'b1;
    data_address           = 32'h200;
    data_write_byte_enable = 4'hF;
    data_write_data        = 32'h1111_1111;
    repeat (4) sb.push_back('{2, 32'h0});
    sb.push_back('{0, 32'h0050_0093});
    sb.push_back('{2, 32'h0});
    acks     = 0;
    code_pos = 0;
    for (int i = 0; i < 60 && acks < 6; i++) begin
      @(negedge clk);
      if (code_ack) begin
        acks++;
        code_pos         = acks;
        code_read_enable = 1'b0;
      end
      if (data_write_ack) begin
        acks++;
        if (acks >= 6) data_write_enable = 1'b0;
      end
    end
    code_read_enable  = 1'b0;
    data_write_enable = 1'b0;
    checkOutput("starve_acks", acks, 32'd6);
    checkOutput("starve_code_pos", code_pos, 32'd5);
    @(negedge clk);

    // Simultaneous read and write: only the write happens
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h300, 4'hF, 32'h1234_5678, 2, 32'h0, "rw");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h300, 4'h0, 32'h0, 1, 32'h1234_5678, "rw_load");

    // Reset during GRANT of a fetch
    code_read_enable = 1'b1;
    code_address     = 32'h40;
    @(negedge clk);
    checkOutput("rg_grant_re", 32'(mem_read_enable), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("rg_re", 32'(mem_read_enable), 32'd0);
    checkOutput("rg_addr", 32'(mem_address), 32'd0);
    checkOutput("rg_busy", 32'(busy), 32'd0);
    checkOutput("rg_code_ack", 32'(code_ack), 32'd0);
    code_read_enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("rg_idle_busy", 32'(busy), 32'd0);
      checkOutput("rg_idle_acks", 32'({code_ack, data_read_ack, data_write_ack}), 32'd0);
    end

    checkOutput("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
